// File: rtl/rr_mux_if.sv
// Handshake bundle for rr_mux: NUM_CH producer channels in, one tagged word out.
// master drives the producer side and out_ready; slave is the multiplexer.
interface rr_mux_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 1
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux.sv
// N-to-1 round-robin multiplexer feeding a one-entry output register slice;
// each output word is tagged with the index of the channel it came from.
module rr_mux #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 1
) (
  input logic   clk,
  input logic   rst,
  rr_mux_if.slave bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_W-1:0] ch_data [NUM_CH];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
  logic [SEL_W-1:0]  last_grant_q, last_grant_d;

  logic              slot_free;
  logic              found;
  logic              grant_en;
  logic [SEL_W-1:0]  grant_idx;
  logic [NUM_CH-1:0] in_ready_c;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = bus.in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    found     = 1'b0;
    grant_idx = '0;
    // Scan starts one past the last winner so the previous grantee has lowest priority.
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!found && bus.in_valid[(int'(last_grant_q) + k) % NUM_CH]) begin
        found     = 1'b1;
        grant_idx = SEL_W'((int'(last_grant_q) + k) % NUM_CH);
      end
    end
    grant_en   = found && slot_free && !rst;
    in_ready_c = '0;
    if (grant_en) begin
      in_ready_c[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    if (grant_en) begin
      out_valid_d  = 1'b1;
      out_data_d   = ch_data[grant_idx];
      out_sel_d    = grant_idx;
      last_grant_d = grant_idx;
    end else if (bus.out_ready) begin
      // Drained with nothing to refill: data and tag keep their last values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      last_grant_q <= SEL_W'(NUM_CH - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_mux.sv
// Bench for rr_mux: vector table on a 2-channel instance, directed sequences and a
// randomized run against a behavioural model on a 4-channel 8-bit instance.
module tb_rr_mux;
  logic clk = 1'b0;
  logic rst2, rst4;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rr_mux_if #(.NUM_CH(2), .DATA_W(1)) bus2 ();
  rr_mux_if #(.NUM_CH(4), .DATA_W(8)) bus4 ();

  rr_mux #(.NUM_CH(2), .DATA_W(1)) dut2 (.clk(clk), .rst(rst2), .bus(bus2.slave));
  rr_mux #(.NUM_CH(4), .DATA_W(8)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));

  typedef struct {
    logic       rst;
    logic [1:0] iv;
    logic [1:0] id;
    logic       ordy;
    logic [1:0] e_ir;
    logic       e_v;
    logic       e_d;
    logic       e_s;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic r, input logic [3:0] iv, input logic ordy);
    rst4 = r;
    bus4.in_valid = iv;
    bus4.out_ready = ordy;
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] ir, input logic v,
                        input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".in_ready"}, 32'(bus4.in_ready), 32'(ir));
    chk({tag, ".out_valid"}, 32'(bus4.out_valid), 32'(v));
    chk({tag, ".out_data"}, 32'(bus4.out_data), 32'(d));
    chk({tag, ".out_sel"}, 32'(bus4.out_sel), 32'(s));
    $display("%s: rst=%0b iv=%b ordy=%0b in_ready=%b out_v=%0b data=%h sel=%0d",
             tag, rst4, bus4.in_valid, bus4.out_ready, bus4.in_ready,
             bus4.out_valid, bus4.out_data, bus4.out_sel);
  endtask

  // First channel at or after last+1 (cyclically) with valid set; -1 if none.
  function automatic int rr_pick(input logic [3:0] iv, input int last);
    for (int off = 1; off <= 4; off++)
      if (iv[(last + off) % 4]) return (last + off) % 4;
    return -1;
  endfunction

  initial begin
    logic [31:0] cdata;
    bit          m_v;
    logic [7:0]  m_d;
    int          m_s, m_last, g;
    logic [3:0]  e_ir;

    rst2 = 1'b1; rst4 = 1'b1;
    bus2.in_valid = '0; bus2.in_data = '0; bus2.out_ready = 1'b0;
    bus4.in_valid = '0; bus4.in_data = '0; bus4.out_ready = 1'b0;
    cyc();

    // rst iv id ordy | in_ready out_v out_d out_sel (outputs seen before the edge)
    vt[0]  = '{1'b1, 2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 2'b11, 2'b10, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1};
    vt[6]  = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1};
    vt[7]  = '{1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 2'b11, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1};
    vt[10] = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      rst2 = vt[i].rst;
      bus2.in_valid = vt[i].iv;
      bus2.in_data = vt[i].id;
      bus2.out_ready = vt[i].ordy;
      #1;
      chk($sformatf("vec%0d.in_ready", i), 32'(bus2.in_ready), 32'(vt[i].e_ir));
      chk($sformatf("vec%0d.out_valid", i), 32'(bus2.out_valid), 32'(vt[i].e_v));
      chk($sformatf("vec%0d.out_data", i), 32'(bus2.out_data), 32'(vt[i].e_d));
      chk($sformatf("vec%0d.out_sel", i), 32'(bus2.out_sel), 32'(vt[i].e_s));
      $display("vec%0d: rst=%0b iv=%b id=%b ordy=%0b in_ready=%b out_v=%0b d=%0b sel=%0d",
               i, rst2, bus2.in_valid, bus2.in_data, bus2.out_ready, bus2.in_ready,
               bus2.out_valid, bus2.out_data, bus2.out_sel);
      cyc();
    end

    // Directed 4-channel sequences; every channel carries A0+i throughout.
    bus4.in_data = 32'hA3A2A1A0;
    drive4(1'b1, 4'b1111, 1'b1);
    check4("rst4", 4'b0000, 1'b0, 8'h00, 2'd0);
    cyc();
    for (int c = 0; c < 8; c++) begin
      drive4(1'b0, 4'b1111, 1'b1);
      if (c == 0) check4("rr0", 4'b0001, 1'b0, 8'h00, 2'd0);
      else check4($sformatf("rr%0d", c), 4'(1 << (c % 4)), 1'b1,
                  8'(8'hA0 + (c - 1) % 4), 2'((c - 1) % 4));
      cyc();
    end
    drive4(1'b0, 4'b0000, 1'b1); check4("rr8", 4'b0000, 1'b1, 8'hA3, 2'd3); cyc();
    drive4(1'b0, 4'b1111, 1'b1); check4("wrap", 4'b0001, 1'b0, 8'hA3, 2'd3); cyc();
    drive4(1'b0, 4'b1111, 1'b1); check4("bp_fill", 4'b0010, 1'b1, 8'hA0, 2'd0); cyc();
    for (int c = 0; c < 3; c++) begin
      drive4(1'b0, 4'b1111, 1'b0);
      check4($sformatf("stall%0d", c), 4'b0000, 1'b1, 8'hA1, 2'd1);
      cyc();
    end
    drive4(1'b0, 4'b1111, 1'b1); check4("bp_release", 4'b0100, 1'b1, 8'hA1, 2'd1); cyc();
    drive4(1'b0, 4'b0011, 1'b1); check4("skip_wrap", 4'b0001, 1'b1, 8'hA2, 2'd2); cyc();
    drive4(1'b0, 4'b0010, 1'b1); check4("pre_rst", 4'b0010, 1'b1, 8'hA0, 2'd0); cyc();
    drive4(1'b1, 4'b1111, 1'b1); check4("mid_rst", 4'b0000, 1'b1, 8'hA1, 2'd1); cyc();
    drive4(1'b0, 4'b1111, 1'b1); check4("post_rst", 4'b0001, 1'b0, 8'h00, 2'd0); cyc();
    drive4(1'b0, 4'b0000, 1'b1); check4("post_rst2", 4'b0000, 1'b1, 8'hA0, 2'd0); cyc();

    // Randomized run against a slot/pointer model.
    drive4(1'b1, 4'b0000, 1'b0);
    cyc();
    m_v = 1'b0; m_d = 8'h00; m_s = 0; m_last = 3;
    for (int t = 0; t < 400; t++) begin
      cdata = $urandom;
      bus4.in_data = cdata;
      drive4(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) != 0));
      g = -1;
      if (!rst4 && (!m_v || bus4.out_ready)) g = rr_pick(bus4.in_valid, m_last);
      e_ir = (g >= 0) ? 4'(1 << g) : 4'b0000;
      check4($sformatf("rnd%0d", t), e_ir, m_v, m_d, 2'(m_s));
      if (rst4) begin
        m_v = 1'b0; m_d = 8'h00; m_s = 0; m_last = 3;
      end else if (g >= 0) begin
        m_v = 1'b1; m_d = cdata[g*8 +: 8]; m_s = g; m_last = g;
      end else if (bus4.out_ready) begin
        m_v = 1'b0;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
